// File: rtl/photon_gate_counter.sv
// Multi-channel gated photon pulse counter: per-window binary/BCD snapshots with a
// valid/ready handshake, plus free-running per-channel BCD accumulators.
module photon_gate_counter #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned GATE_CYCLES = 80000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [NUM_CH-1:0]            pulse,
    input  logic                         acc_clr,
    input  logic                         win_ready,
    output logic                         win_valid,
    output logic [NUM_CH*CNT_W-1:0]      win_bin,
    output logic [NUM_CH*NUM_DIGITS*4-1:0] win_bcd,
    output logic [NUM_CH-1:0]            win_sat,
    output logic                         win_overrun,
    output logic [NUM_CH*NUM_DIGITS*4-1:0] acc_bcd,
    output logic [NUM_CH-1:0]            acc_wrap
);

    localparam int unsigned BW = NUM_DIGITS * 4;
    localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] TERM = GW'(GATE_CYCLES - 1);
    localparam logic [BW-1:0] BCD_MAX = {NUM_DIGITS{4'h9}};

    function automatic logic [CNT_W-1:0] max_bin();
        logic [CNT_W-1:0] m;
        m = CNT_W'(1);
        for (int unsigned d = 0; d < NUM_DIGITS; d++) m = m * CNT_W'(10);
        return m - CNT_W'(1);
    endfunction

    localparam logic [CNT_W-1:0] MAX_BIN = max_bin();

    // Full ripple through every digit in one cycle; all-nines wraps to zero.
    function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (carry) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [GW-1:0]    gate;
    logic [CNT_W-1:0] live_bin [NUM_CH];
    logic [BW-1:0]    live_bcd [NUM_CH];
    logic [NUM_CH-1:0] live_sat;

    logic [CNT_W-1:0] nxt_bin [NUM_CH];
    logic [BW-1:0]    nxt_bcd [NUM_CH];
    logic [NUM_CH-1:0] nxt_sat;
    logic             snap;
    logic             xfer;

    assign snap = en && (gate == TERM);
    assign xfer = win_valid && win_ready;

    // Live count including this cycle's pulse; feeds both the counters and the snapshot.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            nxt_bin[i] = live_bin[i];
            nxt_bcd[i] = live_bcd[i];
            nxt_sat[i] = live_sat[i];
            if (pulse[i]) begin
                if (live_bin[i] == MAX_BIN) begin
                    nxt_sat[i] = 1'b1;
                end else begin
                    nxt_bin[i] = live_bin[i] + CNT_W'(1);
                    nxt_bcd[i] = bcd_inc(live_bcd[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate     <= '0;
            live_sat <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                live_bin[i] <= '0;
                live_bcd[i] <= '0;
            end
        end else if (!en || snap) begin
            gate     <= '0;
            live_sat <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                live_bin[i] <= '0;
                live_bcd[i] <= '0;
            end
        end else begin
            gate     <= gate + GW'(1);
            live_sat <= nxt_sat;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                live_bin[i] <= nxt_bin[i];
                live_bcd[i] <= nxt_bcd[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid   <= 1'b0;
            win_bin     <= '0;
            win_bcd     <= '0;
            win_sat     <= '0;
            win_overrun <= 1'b0;
        end else begin
            win_overrun <= snap && win_valid && !win_ready;
            if (snap) begin
                win_valid <= 1'b1;
                win_sat   <= nxt_sat;
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    win_bin[i*CNT_W +: CNT_W] <= nxt_bin[i];
                    win_bcd[i*BW +: BW]       <= nxt_bcd[i];
                end
            end else if (xfer) begin
                win_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_bcd  <= '0;
            acc_wrap <= '0;
        end else if (acc_clr) begin
            acc_bcd  <= '0;
            acc_wrap <= '0;
        end else if (en) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (pulse[i]) begin
                    acc_bcd[i*BW +: BW] <= bcd_inc(acc_bcd[i*BW +: BW]);
                    if (acc_bcd[i*BW +: BW] == BCD_MAX) acc_wrap[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_photon_gate_counter.sv
// Directed bench for photon_gate_counter: short-gate instance for most cases,
// long-gate instance for BCD saturation.
module tb_photon_gate_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        en = 1'b0, acc_clr = 1'b0, win_ready = 1'b0;
    logic [1:0]  pulse = '0;
    logic        win_valid, win_overrun;
    logic [15:0] win_bin, win_bcd, acc_bcd;
    logic [1:0]  win_sat, acc_wrap;

    logic        en_l = 1'b0, win_ready_l = 1'b0;
    logic [1:0]  pulse_l = '0;
    logic        win_valid_l, win_overrun_l;
    logic [15:0] win_bin_l, win_bcd_l, acc_bcd_l;
    logic [1:0]  win_sat_l, acc_wrap_l;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    photon_gate_counter #(.NUM_CH(2), .NUM_DIGITS(2), .CNT_W(8), .GATE_CYCLES(10)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pulse(pulse), .acc_clr(acc_clr),
        .win_ready(win_ready), .win_valid(win_valid), .win_bin(win_bin), .win_bcd(win_bcd),
        .win_sat(win_sat), .win_overrun(win_overrun), .acc_bcd(acc_bcd), .acc_wrap(acc_wrap)
    );

    photon_gate_counter #(.NUM_CH(2), .NUM_DIGITS(2), .CNT_W(8), .GATE_CYCLES(200)) u_dut_long (
        .clk(clk), .rst_n(rst_n), .en(en_l), .pulse(pulse_l), .acc_clr(1'b0),
        .win_ready(win_ready_l), .win_valid(win_valid_l), .win_bin(win_bin_l),
        .win_bcd(win_bcd_l), .win_sat(win_sat_l), .win_overrun(win_overrun_l),
        .acc_bcd(acc_bcd_l), .acc_wrap(acc_wrap_l)
    );

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        cycles(2);
        check("rst_valid", 32'(win_valid), 32'h0);
        check("rst_bin", 32'(win_bin), 32'h0);
        check("rst_acc", 32'(acc_bcd), 32'h0);
        rst_n = 1'b1;
        cycles(1);

        // 1: 7 pulses on ch0, consumer ready
        en = 1'b1; win_ready = 1'b1; pulse = 2'b01;
        cycles(7);
        pulse = 2'b00;
        cycles(3);
        check("t1_valid", 32'(win_valid), 32'h1);
        check("t1_bin0", 32'(win_bin[7:0]), 32'h07);
        check("t1_bcd0", 32'(win_bcd[7:0]), 32'h07);
        check("t1_bin1", 32'(win_bin[15:8]), 32'h00);
        check("t1_bcd1", 32'(win_bcd[15:8]), 32'h00);
        cycles(1);
        check("t1_valid_drop", 32'(win_valid), 32'h0);
        check("t1_acc", 32'(acc_bcd), 32'h0007);
        en = 1'b0;
        cycles(1);

        // 2: ch0 high for three full windows
        acc_clr = 1'b1;
        cycles(1);
        acc_clr = 1'b0;
        check("t2_acc_clr", 32'(acc_bcd), 32'h0);
        en = 1'b1; pulse = 2'b01;
        for (int w = 0; w < 3; w++) begin
            cycles(10);
            check("t2_valid", 32'(win_valid), 32'h1);
            check("t2_bin0", 32'(win_bin[7:0]), 32'h0a);
            check("t2_bcd0", 32'(win_bcd[7:0]), 32'h10);
            check("t2_sat", 32'(win_sat), 32'h0);
        end
        pulse = 2'b00;
        check("t2_acc", 32'(acc_bcd[7:0]), 32'h30);
        en = 1'b0;
        cycles(2);

        // 4: consumer stalled across two windows
        win_ready = 1'b0; en = 1'b1; pulse = 2'b01;
        cycles(5);
        pulse = 2'b00;
        cycles(5);
        check("t4_valid1", 32'(win_valid), 32'h1);
        check("t4_bin_first", 32'(win_bin[7:0]), 32'h05);
        check("t4_no_overrun", 32'(win_overrun), 32'h0);
        pulse = 2'b01;
        cycles(3);
        pulse = 2'b00;
        cycles(7);
        check("t4_overrun", 32'(win_overrun), 32'h1);
        check("t4_bin_second", 32'(win_bin[7:0]), 32'h03);
        cycles(1);
        check("t4_overrun_strobe", 32'(win_overrun), 32'h0);
        check("t4_held_valid", 32'(win_valid), 32'h1);
        check("t4_held_bin", 32'(win_bin[7:0]), 32'h03);
        win_ready = 1'b1; en = 1'b0;
        cycles(1);
        check("t4_xfer", 32'(win_valid), 32'h0);

        // 5: pulse on the terminal cycle only
        en = 1'b1;
        cycles(9);
        pulse = 2'b01;
        cycles(1);
        pulse = 2'b00;
        check("t5_term_bin", 32'(win_bin[7:0]), 32'h01);
        check("t5_term_valid", 32'(win_valid), 32'h1);
        cycles(10);
        check("t5_next_valid", 32'(win_valid), 32'h1);
        check("t5_next_bin", 32'(win_bin[7:0]), 32'h00);
        check("t5_acc", 32'(acc_bcd[7:0]), 32'h39);
        en = 1'b0;
        cycles(1);

        // 6: accumulator wrap and clear
        acc_clr = 1'b1;
        cycles(1);
        acc_clr = 1'b0; en = 1'b1; pulse = 2'b01;
        cycles(98);
        check("t6_acc98", 32'(acc_bcd[7:0]), 32'h98);
        check("t6_nowrap", 32'(acc_wrap), 32'h0);
        cycles(3);
        check("t6_acc_wrapped", 32'(acc_bcd), 32'h0001);
        check("t6_wrap", 32'(acc_wrap), 32'h1);
        acc_clr = 1'b1;
        cycles(1);
        check("t6_clr_acc", 32'(acc_bcd), 32'h0);
        check("t6_clr_wrap", 32'(acc_wrap), 32'h0);
        acc_clr = 1'b0; pulse = 2'b00; en = 1'b0;
        cycles(1);

        // 7: en dropped mid-window, then async reset with a pending snapshot
        en = 1'b1; pulse = 2'b01;
        cycles(4);
        check("t7_acc4", 32'(acc_bcd[7:0]), 32'h04);
        en = 1'b0;
        cycles(12);
        check("t7_no_valid", 32'(win_valid), 32'h0);
        check("t7_acc_hold", 32'(acc_bcd[7:0]), 32'h04);
        pulse = 2'b00; en = 1'b1;
        cycles(10);
        check("t7_live_cleared", 32'(win_bin[7:0]), 32'h00);
        check("t7_valid", 32'(win_valid), 32'h1);
        win_ready = 1'b0; pulse = 2'b01;
        cycles(10);
        check("t7_pending_bin", 32'(win_bin[7:0]), 32'h0a);
        check("t7_acc14", 32'(acc_bcd[7:0]), 32'h14);
        cycles(3);
        rst_n = 1'b0;
        #1;
        check("t7_rst_valid", 32'(win_valid), 32'h0);
        check("t7_rst_bin", 32'(win_bin), 32'h0);
        check("t7_rst_bcd", 32'(win_bcd), 32'h0);
        check("t7_rst_acc", 32'(acc_bcd), 32'h0);
        pulse = 2'b00; en = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        cycles(1);

        // 3: saturation on the 200-cycle gate instance
        en_l = 1'b1; win_ready_l = 1'b1; pulse_l = 2'b01;
        cycles(150);
        pulse_l = 2'b00;
        cycles(50);
        check("t3_valid", 32'(win_valid_l), 32'h1);
        check("t3_bin0", 32'(win_bin_l[7:0]), 32'h63);
        check("t3_bcd0", 32'(win_bcd_l[7:0]), 32'h99);
        check("t3_sat", 32'(win_sat_l), 32'h1);
        check("t3_acc", 32'(acc_bcd_l), 32'h0050);
        check("t3_acc_wrap", 32'(acc_wrap_l), 32'h1);
        cycles(200);
        check("t3_next_sat", 32'(win_sat_l), 32'h0);
        check("t3_next_bin", 32'(win_bin_l[7:0]), 32'h00);
        en_l = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
